// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encoding, slot states and divide-by-zero result
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
  } op_t;
  typedef enum logic {EMPTY, FULL} slot_state_t;
  localparam logic [7:0] DIV0_RESULT = 8'hFF;
endpackage

// File: rtl/alu.sv
// alu: 8-bit combinational ALU; carry is always the 9-bit sum carry
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  op_t        op,
  output logic [7:0] result,
  output logic       carry
);
  logic [8:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
  assign carry = sum[8];
  // op decode; divide by zero is left to the caller to override
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = sum[7:0];
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_DIV:  result = a / b;
      OP_SHL:  result = {a[6:0], 1'b0};
      OP_SHR:  result = {1'b0, a[7:1]};
      OP_ROL:  result = {a[6:0], a[7]};
      OP_ROR:  result = {a[0], a[7:1]};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_NAND: result = ~(a & b);
      OP_XNOR: result = ~(a ^ b);
      OP_GT:   result = {7'd0, a > b};
      OP_EQ:   result = {7'd0, a == b};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr, wrapping N_REQ-1 -> 0
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);
  logic [ID_W:0] pos;
  // scan farthest-first so the requester nearest the pointer is written last and wins
  always_comb begin
    grant = '0;
    idx = '0;
    pos = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (ID_W + 1)'(k);
      pos = (pos >= (ID_W + 1)'(N_REQ)) ? pos - (ID_W + 1)'(N_REQ) : pos;
      if (en && req[pos]) begin
        grant = '0;
        grant[pos] = 1'b1;
        idx = pos[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU among N_REQ requesters with a one-entry response slot
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  input  logic [4*N_REQ-1:0] req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_result,
  output logic               rsp_carry,
  output logic               rsp_div0
);
  slot_state_t      state;
  logic [ID_W-1:0]  ptr, idx, ptr_nxt;
  logic [N_REQ-1:0] grant;
  logic             load, xfer, div0, carry;
  logic [7:0]       a, b, alu_res;
  op_t              op;
  assign rsp_valid = state == FULL;
  assign load = (state == EMPTY) | (rsp_valid & rsp_ready);
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req_valid), .ptr(ptr), .en(load), .grant(grant), .idx(idx)
  );
  assign req_ready = grant & {N_REQ{load}};
  assign xfer = |req_ready;
  assign a = req_a[idx*8 +: 8];
  assign b = req_b[idx*8 +: 8];
  assign op = op_t'(req_sel[idx*4 +: 4]);
  assign div0 = (op == OP_DIV) && (b == 8'd0);
  assign ptr_nxt = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  alu u_alu (.a(a), .b(b), .op(op), .result(alu_res), .carry(carry));
  // slot FSM: load on transfer, drain to EMPTY when consumed without a refill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr <= '0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_carry <= 1'b0;
      rsp_div0 <= 1'b0;
    end else if (xfer) begin
      state <= FULL;
      ptr <= ptr_nxt;
      rsp_id <= idx;
      rsp_result <= div0 ? DIV0_RESULT : alu_res;
      rsp_carry <= carry;
      rsp_div0 <= div0;
    end else if (rsp_valid && rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and random checks against a behavioural slot/arbiter/ALU model
module tb_alu_share_ctrl;
  logic        clk, rst_n, rsp_ready;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] req_sel;
  logic        rsp_valid, rsp_carry, rsp_div0;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic [7:0]  ta[4], tb_b[4];
  logic [3:0]  ts[4];
  int total = 0, bad = 0;
  int m_valid = 0, m_id = 0, m_res = 0, m_carry = 0, m_div0 = 0, m_ptr = 0;
  assign req_a = {ta[3], ta[2], ta[1], ta[0]};
  assign req_b = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};
  assign req_sel = {ts[3], ts[2], ts[1], ts[0]};
  alu_share_ctrl #(.N_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_div0(rsp_div0)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int ref_res(input int a, input int b, input int s);
    int r;
    case (s)
      0: r = a + b;
      1: r = a - b + 256;
      2: r = a * b;
      3: r = (b == 0) ? 255 : a / b;
      4: r = a * 2;
      5: r = a / 2;
      6: r = a * 2 + a / 128;
      7: r = a / 2 + (a % 2) * 128;
      8: r = a & b;
      9: r = a | b;
      10: r = a ^ b;
      11: r = ~(a | b);
      12: r = ~(a & b);
      13: r = ~(a ^ b);
      14: r = (a > b) ? 1 : 0;
      default: r = (a == b) ? 1 : 0;
    endcase
    return r & 255;
  endfunction
  task automatic cycle(output logic [3:0] rr);
    int g;
    bit load;
    @(negedge clk);
    rr = req_ready;
    load = (m_valid == 0) || rsp_ready;
    g = -1;
    if (load)
      for (int k = 0; k < 4; k++)
        if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    chk("req_ready", rr, (g < 0) ? 0 : (1 << g));
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_id", rsp_id, m_id);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_carry", rsp_carry, m_carry);
    chk("rsp_div0", rsp_div0, m_div0);
    if (!rst_n) begin
      m_valid = 0; m_id = 0; m_res = 0; m_carry = 0; m_div0 = 0; m_ptr = 0;
    end else begin
      if (m_valid != 0 && rsp_ready) m_valid = 0;
      if (g >= 0) begin
        m_valid = 1;
        m_id = g;
        m_res = ref_res(int'(ta[g]), int'(tb_b[g]), int'(ts[g]));
        m_carry = (int'(ta[g]) + int'(tb_b[g]) > 255) ? 1 : 0;
        m_div0 = (ts[g] == 4'd3 && tb_b[g] == 8'd0) ? 1 : 0;
        m_ptr = (g + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] rr, pend;
    logic [7:0] hold_res;
    logic [1:0] hold_id;
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0;
    for (int i = 0; i < 4; i++) begin ta[i] = '0; tb_b[i] = '0; ts[i] = '0; end
    @(posedge clk);
    #1;
    cycle(rr);
    rst_n = 1'b1;
    cycle(rr);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_result", rsp_result, 0);
    ta[0] = 8'd200; tb_b[0] = 8'd100; ts[0] = 4'd0; req_valid = 4'b0001;
    cycle(rr);
    chk("single_ready", rr, 4'b0001);
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_result", rsp_result, 44);
    chk("single_carry", rsp_carry, 1);
    chk("single_div0", rsp_div0, 0);
    req_valid = '0; rsp_ready = 1'b1;
    cycle(rr);
    rst_n = 1'b0;
    cycle(rr);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ta[i] = 8'($urandom); tb_b[i] = 8'($urandom); ts[i] = 4'($urandom);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      cycle(rr);
      chk("fair_grant", rr, 1 << (k % 4));
      chk("fair_valid", rsp_valid, 1);
      chk("fair_id", rsp_id, k % 4);
    end
    rsp_ready = 1'b0; req_valid = 4'b0100;
    hold_res = rsp_result; hold_id = rsp_id;
    for (int k = 0; k < 3; k++) begin
      cycle(rr);
      chk("bp_ready", rr, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, hold_res);
      chk("bp_id", rsp_id, hold_id);
    end
    rsp_ready = 1'b1;
    cycle(rr);
    chk("bp_accept", rr, 4'b0100);
    chk("bp_new_id", rsp_id, 2);
    chk("bp_new_valid", rsp_valid, 1);
    ta[1] = 8'd7; tb_b[1] = 8'd0; ts[1] = 4'd3; req_valid = 4'b0010;
    cycle(rr);
    chk("div0_result", rsp_result, 8'hFF);
    chk("div0_flag", rsp_div0, 1);
    chk("div0_carry", rsp_carry, 0);
    ta[1] = 8'd100; tb_b[1] = 8'd7;
    cycle(rr);
    chk("div_result", rsp_result, 14);
    chk("div_flag", rsp_div0, 0);
    req_valid = 4'b0100;
    cycle(rr);
    chk("pre_rst_id", rsp_id, 2);
    req_valid = '0; rsp_ready = 1'b0; rst_n = 1'b0;
    cycle(rr);
    rst_n = 1'b1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_result", rsp_result, 0);
    chk("mid_rst_carry", rsp_carry, 0);
    chk("mid_rst_div0", rsp_div0, 0);
    req_valid = 4'b1001; rsp_ready = 1'b1;
    cycle(rr);
    chk("mid_rst_grant", rr, 4'b0001);
    for (int n = 0; n < 400; n++) begin
      pend = req_valid & ~rr;
      for (int i = 0; i < 4; i++) begin
        if (!(pend[i] && $urandom_range(0, 9) != 0)) begin
          req_valid[i] = $urandom_range(0, 2) != 0;
          ta[i] = 8'($urandom);
          tb_b[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
          ts[i] = ($urandom_range(0, 5) == 0) ? 4'd3 : 4'($urandom);
        end
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      cycle(rr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one 8-bit ALU between N_REQ requesters over valid/ready handshakes.
- Each accepted request (A, B, 4-bit op select) goes through the ALU. The result is registered in a single-entry response slot, tagged with the requester index.
- Sits between the requesting units and the shared ALU.
- Also defines divide-by-zero behaviour, which the raw ALU leaves undefined.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), localparam: width of the requester index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  8*N_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  in  8*N_REQ  operand B, same packing as req_a.
- req_sel  in  4*N_REQ  ALU op select, 4 bits per requester, ALU encoding 0000..1111.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that produced the response.
- rsp_result  out  8  ALU result.
- rsp_carry  out  1  carry of the 9-bit sum {0,A}+{0,B}; produced for every op, not only add.
- rsp_div0  out  1  set when op is 0011 and B is 0.

Behaviour:
- Reset (rst_n low at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_div0=0.
  - Round-robin pointer=0; state=EMPTY.
  - Reset overrides everything. A pending response is discarded, with no requester notified.
- Slot load condition: load = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - Grant the first i with req_valid[i]=1, searching from the pointer upward with wrap N_REQ-1 -> 0.
  - req_ready[i] = grant[i] & load.
  - req_ready never depends on requesters other than via arbitration.
- Handshake rules:
  - Transfer on req_valid[i] & req_ready[i].
  - A requester holds valid and payload stable until accepted. Dropping valid before acceptance is legal; that requester is then skipped.
  - A response transfers on rsp_valid & rsp_ready.
  - While rsp_valid=1 and rsp_ready=0, all rsp_* outputs stay stable.
- On a transfer from requester g:
  - Next cycle: rsp_valid=1, rsp_id=g, rsp_result, rsp_carry and rsp_div0 from the granted operands.
  - Pointer = (g+1) mod N_REQ.
  - Latency is 1 cycle, request edge to rsp_valid.
- Throughput:
  - One op per cycle when rsp_ready is held high.
  - Accepting a new request in the same cycle the current response is consumed is required (no bubble).
- Pointer update: the pointer changes only on a transfer.
- States and transitions:
  - EMPTY -> FULL on a transfer.
  - FULL -> FULL when a response is consumed and a new transfer occurs in the same cycle.
  - FULL -> EMPTY when a response is consumed with no transfer.
  - FULL holds otherwise.
- Division by zero (op 0011, B=0):
  - rsp_result=8'hFF, rsp_div0=1.
  - No X may propagate.
  - rsp_div0=0 for every other case.
- Arithmetic: all results truncated to 8 bits; subtraction and multiplication wrap modulo 256.
- Ops 1110 and 1111 return 8'd1 or 8'd0; the comparison is unsigned.
- No request valid: req_ready stays all-zero effectively, the state is unchanged, and the pointer holds.

Decomposition:
- Shared package alu_pkg:
  - 4-bit op enum (ADD, SUB, MUL, DIV, SHL, SHR, ROL, ROR, AND, OR, XOR, NOR, NAND, XNOR, GT, EQ).
  - Constant DIV0_RESULT=8'hFF.
- Sub-module rr_arbiter:
  - Parameterised N_REQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
- The existing alu module is instantiated once on the granted operands. The div0 override is applied around it.

Test Plan:
- Single request, req0: A=200, B=100, sel=0000 -> next cycle rsp_valid=1, id=0, result=44, carry=1, div0=0.
- Fairness:
  - Stimulus: all four req_valid held high, rsp_ready=1, pointer 0 after reset.
  - Required: grants 0,1,2,3,0,1 on consecutive cycles, one response per cycle, no gap.
- Backpressure, part 1:
  - Stimulus: response held with rsp_ready=0 for 3 cycles while req2 is valid.
  - Required: req_ready=0000 and rsp_* stable.
- Backpressure, part 2:
  - Stimulus: raise rsp_ready.
  - Required: req2 accepted in that same cycle, with its response visible the next cycle.
- Divide, req1:
  - A=7, B=0, sel=0011 -> result=8'hFF, div0=1, carry=0.
  - A=100, B=7, sel=0011 -> result=14, div0=0.
- Reset mid-operation:
  - Stimulus: rsp_valid=1, pointer=3, rst_n low for one edge.
  - Required: rsp_valid=0, all rsp_* zero.
  - Follow-up: req0 and req3 then both valid -> req0 granted first.
